// File: rtl/eq_pkg.sv
// eq_pkg: shared constants and FSM encoding for the equalizer band sequencer.
// Holds the Q2.14 gain constants and the output saturation bounds.

package eq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ACC,
        ST_OUT
    } eq_state_t;

    // Unity gain in Q2.14
    localparam logic [15:0] GAIN_ONE = 16'h4000;

    // Fractional bits of the gain format; the accumulator is shifted by this
    localparam int Q_SHIFT = 14;

    // Output clipping range for a signed 16-bit sample
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

endpackage

// File: rtl/eq_gain_mac.sv
// eq_gain_mac: multiplies one band output by its gain, accumulates the
// products over a frame and presents the shifted, saturated result.
// Optional macro EQ_SAT_CNT_EN exposes the saturation flag as sat_o.

import eq_pkg::*;

module eq_gain_mac #(
    parameter int DATA_W = 16,
    parameter int GAIN_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     acc_en_i,
    input  logic signed [DATA_W-1:0] y_i,
    input  logic signed [GAIN_W-1:0] gain_i,
    output logic signed [DATA_W-1:0] result_o
`ifdef EQ_SAT_CNT_EN
    ,
    output logic                     sat_o
`endif
);

    localparam int PROD_W = DATA_W + GAIN_W;

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(SAT_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(SAT_MIN);

    logic signed [PROD_W-1:0] product;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  shifted;
    logic                     satHi;
    logic                     satLo;

    // Full-precision product, sign-extended into the wider accumulator
    always_comb begin
        product = y_i * gain_i;
        acc_d   = acc_q + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    end

    // Accumulator is cleared at frame start and summed once per band
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (clear_i) begin
            acc_q <= '0;
        end else if (acc_en_i) begin
            acc_q <= acc_d;
        end
    end

    // Drop the Q2.14 fraction and clip to the signed sample range
    always_comb begin
        shifted = acc_q >>> Q_SHIFT;
        satHi   = shifted > SAT_HI;
        satLo   = shifted < SAT_LO;
        if (satHi) begin
            result_o = DATA_W'(SAT_MAX);
        end else if (satLo) begin
            result_o = DATA_W'(SAT_MIN);
        end else begin
            result_o = shifted[DATA_W-1:0];
        end
    end

`ifdef EQ_SAT_CNT_EN
    assign sat_o = satHi | satLo;
`endif

endmodule

// File: rtl/eq_band_sequencer.sv
// eq_band_sequencer: runs the FIR band cores one at a time for each sample,
// weights each band output by its gain and emits the saturated sum.
// Optional macro EQ_SAT_CNT_EN enables the saturation event counter.

import eq_pkg::*;

module eq_band_sequencer #(
    parameter int NUM_BAND    = 5,
    parameter int DATA_W      = 16,
    parameter int GAIN_W      = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_data,
    output logic [DATA_W-1:0]          band_x,
    output logic [NUM_BAND-1:0]        band_start,
    input  logic [NUM_BAND-1:0]        band_done,
    input  logic [NUM_BAND*DATA_W-1:0] band_y,
    input  logic                       gain_we,
    input  logic [2:0]                 gain_addr,
    input  logic [GAIN_W-1:0]          gain_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [NUM_BAND-1:0]        err_timeout,
    output logic [15:0]                sat_cnt
);

    localparam int KW    = (NUM_BAND > 1) ? $clog2(NUM_BAND) : 1;
    localparam int CW    = $clog2(TIMEOUT_CYC);
    localparam int ACC_W = DATA_W + GAIN_W + $clog2(NUM_BAND);

    eq_state_t                 state_q;
    logic [KW-1:0]             k_q;
    logic [CW-1:0]             cnt_q;
    logic                      s_ready_q;
    logic [DATA_W-1:0]         band_x_q;
    logic [NUM_BAND-1:0]       band_start_q;
    logic                      m_valid_q;
    logic [DATA_W-1:0]         m_data_q;
    logic [NUM_BAND-1:0]       err_q;
    logic signed [DATA_W-1:0]  yCap_q;
    logic signed [GAIN_W-1:0]  pendGain_q   [NUM_BAND];
    logic signed [GAIN_W-1:0]  activeGain_q [NUM_BAND];
    logic signed [DATA_W-1:0]  bandYArr     [NUM_BAND];
    logic signed [DATA_W-1:0]  macResult;
    logic                      macClear;
    logic                      macAccEn;
    logic                      accept;

    assign accept   = (state_q == ST_IDLE) && s_valid && s_ready_q;
    assign macClear = accept;
    assign macAccEn = (state_q == ST_ACC);

    // Unflatten the band outputs so the active band can be picked by index
    always_comb begin
        for (int i = 0; i < NUM_BAND; i++) begin
            bandYArr[i] = band_y[i*DATA_W +: DATA_W];
        end
    end

    // Gain writes land in the pending bank at any time; bad indices are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BAND; i++) begin
                pendGain_q[i] <= GAIN_W'(GAIN_ONE);
            end
        end else if (gain_we && (int'(gain_addr) < NUM_BAND)) begin
            pendGain_q[gain_addr] <= gain_data;
        end
    end

    // Frame sequencer: accept, then start/wait/accumulate each band, then output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            k_q          <= '0;
            cnt_q        <= '0;
            s_ready_q    <= 1'b0;
            band_x_q     <= '0;
            band_start_q <= '0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            err_q        <= '0;
            yCap_q       <= '0;
            for (int i = 0; i < NUM_BAND; i++) begin
                activeGain_q[i] <= GAIN_W'(GAIN_ONE);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        band_x_q     <= s_data;
                        activeGain_q <= pendGain_q;
                        k_q          <= '0;
                        band_start_q <= NUM_BAND'(1);
                        s_ready_q    <= 1'b0;
                        state_q      <= ST_START;
                    end else begin
                        s_ready_q <= 1'b1;
                    end
                end
                ST_START: begin
                    band_start_q <= '0;
                    cnt_q        <= '0;
                    state_q      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (band_done[k_q]) begin
                        yCap_q  <= bandYArr[k_q];
                        state_q <= ST_ACC;
                    end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                        err_q[k_q] <= 1'b1;
                        yCap_q     <= '0;
                        state_q    <= ST_ACC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ACC: begin
                    if (k_q == KW'(NUM_BAND - 1)) begin
                        state_q <= ST_OUT;
                    end else begin
                        k_q          <= k_q + 1'b1;
                        band_start_q <= NUM_BAND'(1) << (k_q + 1'b1);
                        state_q      <= ST_START;
                    end
                end
                ST_OUT: begin
                    if (!m_valid_q) begin
                        m_data_q  <= macResult;
                        m_valid_q <= 1'b1;
                    end else if (m_ready) begin
                        m_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef EQ_SAT_CNT_EN
    logic        macSat;
    logic [15:0] satCnt_q;

    // Count clipped outputs at the moment they are loaded, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            satCnt_q <= '0;
        end else if ((state_q == ST_OUT) && !m_valid_q && macSat && (satCnt_q != 16'hFFFF)) begin
            satCnt_q <= satCnt_q + 1'b1;
        end
    end

    assign sat_cnt = satCnt_q;
`else
    assign sat_cnt = '0;
`endif

    eq_gain_mac #(
        .DATA_W (DATA_W),
        .GAIN_W (GAIN_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (macClear),
        .acc_en_i (macAccEn),
        .y_i      (yCap_q),
        .gain_i   (activeGain_q[k_q]),
        .result_o (macResult)
`ifdef EQ_SAT_CNT_EN
        ,
        .sat_o    (macSat)
`endif
    );

    assign s_ready     = s_ready_q;
    assign band_x      = band_x_q;
    assign band_start  = band_start_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// tb_eq_band_sequencer: drives samples, gain writes and band-core responses,
// and compares the sequencer outputs with a frame-level arithmetic model.

`timescale 1ns/1ps

module tb_eq_band_sequencer;

    localparam int NB  = 5;
    localparam int TO  = 1024;
    localparam int LIM = 8000;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           s_valid;
    logic           s_ready;
    logic [15:0]    s_data;
    logic [15:0]    band_x;
    logic [NB-1:0]  band_start;
    logic [NB-1:0]  band_done;
    logic [NB*16-1:0] band_y;
    logic           gain_we;
    logic [2:0]     gain_addr;
    logic [15:0]    gain_data;
    logic           m_valid;
    logic           m_ready;
    logic [15:0]    m_data;
    logic [NB-1:0]  err_timeout;
    logic [15:0]    sat_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // per-band response: delay in cycles after start (0 = never), value
    int                 bandDelay [NB];
    logic signed [15:0] bandVal   [NB];
    int                 cntB      [NB];
    int                 curBand   = -1;
    bit                 noiseEn   = 1'b0;
    bit                 readyRand = 1'b0;

    // reference model state
    logic signed [15:0] pendM [NB];
    logic signed [15:0] actM  [NB];
    logic [15:0]        expX;
    logic [15:0]        expData;
    logic [NB-1:0]      expErr;
    logic [15:0]        expSat;
    int                 expLat;
    int                 acceptCyc;
    int                 lastLat;
    int                 clipFrames = 0;
    bit                 seenValid = 1'b1;
    logic [15:0]        lastData;

    eq_band_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .band_x      (band_x),
        .band_start  (band_start),
        .band_done   (band_done),
        .band_y      (band_y),
        .gain_we     (gain_we),
        .gain_addr   (gain_addr),
        .gain_data   (gain_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .err_timeout (err_timeout),
        .sat_cnt     (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame result from the gain/sum rules: weighted sum, Q2.14 shift, clip
    function automatic void predict();
        longint acc = 0;
        longint q;
        int     w;
        bit     clip = 1'b0;
        expLat = 2;
        for (int i = 0; i < NB; i++) begin
            if (bandDelay[i] > 0 && bandDelay[i] <= TO) begin
                acc += longint'(bandVal[i]) * longint'(actM[i]);
                w = bandDelay[i];
            end else begin
                expErr[i] = 1'b1;
                w = TO;
            end
            expLat += 2 + w;
        end
        q = acc >>> 14;
        if (q > 32767) begin
            q = 32767;
            clip = 1'b1;
        end else if (q < -32768) begin
            q = -32768;
            clip = 1'b1;
        end
        expData = 16'(q);
        if (clip) clipFrames++;
`ifdef EQ_SAT_CNT_EN
        if (clip && expSat != 16'hFFFF) expSat = expSat + 16'd1;
`endif
    endfunction

    // Band cores: answer each start after its configured delay, plus optional noise
    always @(posedge clk) begin
        #1;
        band_done = '0;
        if (noiseEn) begin
            for (int i = 0; i < NB; i++) begin
                if (i != curBand && $urandom_range(0, 3) == 0) begin
                    band_done[i] = 1'b1;
                    band_y[i*16 +: 16] = 16'($urandom);
                end
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (cntB[i] > 0) begin
                cntB[i]--;
                if (cntB[i] == 0) begin
                    band_done[i] = 1'b1;
                    band_y[i*16 +: 16] = bandVal[i];
                end
            end
        end
        for (int i = 0; i < NB; i++) begin
            if (band_start[i]) begin
                cntB[i] = bandDelay[i];
                curBand = i;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (readyRand) m_ready = 1'($urandom_range(0, 1));
    end

    // Model update and per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) pendM[i] = 16'sh4000;
            expX      = '0;
            expErr    = '0;
            expSat    = '0;
            seenValid = 1'b1;
        end else begin
            checkOutput("band_x", band_x, expX);
            checkOutput("start_onehot", ($countones(band_start) <= 1), 1);
            if (m_valid) begin
                checkOutput("m_data", m_data, expData);
                checkOutput("err_timeout", err_timeout, expErr);
                checkOutput("sat_cnt", sat_cnt, expSat);
                checkOutput("s_ready_in_out", s_ready, 0);
                if (!seenValid) begin
                    lastLat = cyc - acceptCyc;
                    checkOutput("latency", lastLat, expLat);
                    seenValid = 1'b1;
                end
            end
            if (s_valid && s_ready) begin
                for (int i = 0; i < NB; i++) actM[i] = pendM[i];
                expX      = s_data;
                acceptCyc = cyc;
                seenValid = 1'b0;
                predict();
            end
            if (gain_we && gain_addr < 3'(NB)) pendM[gain_addr] = gain_data;
        end
    end

    task automatic applyStimulus(input logic [15:0] x);
        int n = 0;
        @(posedge clk); #1;
        s_valid = 1'b1;
        s_data  = x;
        @(negedge clk);
        while (!s_ready && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) checkOutput("accept_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic waitOutput();
        int n = 0;
        @(negedge clk);
        while (!(m_valid && m_ready) && n < LIM) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIM) checkOutput("output_timeout", 0, 1);
        lastData = m_data;
        @(posedge clk); #1;
    endtask

    task automatic writeGain(input logic [2:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        gain_we = 1'b1; gain_addr = a; gain_data = d;
        @(posedge clk); #1;
        gain_we = 1'b0;
    endtask

    task automatic setBands(input logic [15:0] v, input int d);
        for (int i = 0; i < NB; i++) begin
            bandVal[i]   = v;
            bandDelay[i] = d;
        end
    endtask

    initial begin
        logic [15:0] held;
        int n;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; band_done = '0; band_y = '0;
        gain_we = 1'b0; gain_addr = '0; gain_data = '0; m_ready = 1'b1;
        for (int i = 0; i < NB; i++) cntB[i] = 0;
        setBands(16'h0000, 1);

        @(negedge clk);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_band_start", band_start, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // unity gains, all bands 0x0800, immediate done
        setBands(16'h0800, 1);
        applyStimulus(16'h1000);
        waitOutput();
        checkOutput("t1_data", lastData, 16'h2800);
        checkOutput("t1_latency", lastLat, 17);

        // band 2 muted before the sample
        writeGain(3'd2, 16'h0000);
        setBands(16'h1000, 1);
        applyStimulus(16'h0123);
        waitOutput();
        checkOutput("t2_data", lastData, 16'h4000);

        // mute written mid-frame only affects the following frame
        writeGain(3'd2, 16'h4000);
        applyStimulus(16'h0456);
        writeGain(3'd2, 16'h0000);
        waitOutput();
        checkOutput("t3_cur", lastData, 16'h5000);
        applyStimulus(16'h0789);
        waitOutput();
        checkOutput("t3_next", lastData, 16'h4000);
        writeGain(3'd2, 16'h4000);
        writeGain(3'd7, 16'h0000);

        // saturation at full scale
        setBands(16'h7FFF, 1);
        applyStimulus(16'h7FFF);
        waitOutput();
        checkOutput("t4_data", lastData, 16'h7FFF);
`ifdef EQ_SAT_CNT_EN
        checkOutput("t4_sat_cnt", sat_cnt, 1);
`else
        checkOutput("t4_sat_cnt", sat_cnt, 0);
`endif

        // band 3 never answers
        bandVal[0] = 16'h0100; bandVal[1] = 16'h0200; bandVal[2] = 16'h0300;
        bandVal[3] = 16'h0400; bandVal[4] = 16'h0500;
        bandDelay[3] = 0;
        applyStimulus(16'h0001);
        waitOutput();
        checkOutput("t5_data", lastData, 16'h0B00);
        checkOutput("t5_err", err_timeout, 5'b01000);

        // done on the last allowed cycle counts; one later times out
        bandDelay[3] = 1; bandDelay[1] = TO;
        applyStimulus(16'h0002);
        waitOutput();
        checkOutput("t6_edge_data", lastData, 16'h0F00);
        checkOutput("t6_edge_err", err_timeout, 5'b01000);
        bandDelay[1] = 1; bandDelay[4] = TO + 1;
        applyStimulus(16'h0003);
        waitOutput();
        checkOutput("t6_late_data", lastData, 16'h0A00);
        checkOutput("t6_late_err", err_timeout, 5'b11000);

        // downstream stall: output held, no new sample accepted
        setBands(16'h0200, 1);
        m_ready = 1'b0;
        applyStimulus(16'h0AAA);
        n = 0;
        @(negedge clk);
        while (!m_valid && n < LIM) begin @(negedge clk); n++; end
        held = m_data;
        checkOutput("t7_held_value", held, 16'h0A00);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = 16'h0BBB;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("t7_m_valid", m_valid, 1);
            checkOutput("t7_m_data", m_data, held);
            checkOutput("t7_s_ready", s_ready, 0);
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        applyStimulus(16'h0BBB);
        waitOutput();
        checkOutput("t7_next", lastData, 16'h0A00);

        // reset while waiting on band 2
        bandDelay[2] = 0;
        applyStimulus(16'h0CCC);
        n = 0;
        @(negedge clk);
        while (!band_start[2] && n < 200) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t8_s_ready", s_ready, 0);
        checkOutput("t8_band_start", band_start, 0);
        checkOutput("t8_band_x", band_x, 0);
        checkOutput("t8_m_valid", m_valid, 0);
        checkOutput("t8_m_data", m_data, 0);
        checkOutput("t8_err", err_timeout, 0);
        checkOutput("t8_sat_cnt", sat_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bandDelay[2] = 1;
        bandVal[0] = 16'h0010; bandVal[1] = 16'h0020; bandVal[2] = 16'h0030;
        bandVal[3] = 16'h0040; bandVal[4] = 16'h0050;
        applyStimulus(16'h0DDD);
        waitOutput();
        checkOutput("t8_after", lastData, 16'h00F0);
        checkOutput("t8_after_lat", lastLat, 17);

        // randomized frames with gain writes, spurious dones and backpressure
        noiseEn = 1'b1;
        readyRand = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int i = 0; i < NB; i++) begin
                bandVal[i]   = 16'($urandom);
                bandDelay[i] = $urandom_range(1, 4);
            end
            n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) writeGain(3'($urandom_range(0, 7)), 16'($urandom));
            applyStimulus(16'($urandom));
            if ($urandom_range(0, 1) == 1) writeGain(3'($urandom_range(0, 7)), 16'($urandom));
            waitOutput();
        end
        readyRand = 1'b0;
        noiseEn = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] clipped frames in model: %0d", clipFrames);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eq_band_sequencer.md
Name: eq_band_sequencer

Overview:
Sequences the five FIR band filters of the audio equalizer for each incoming sample. The band cores share one multiplier bank, so only one band may run at a time. The block starts each band in turn, collects its output, applies a per-band gain and sums the weighted results. It sits between the sample source (I2S receive path) and the equalizer output stage.

Parameters:
NUM_BAND, 5, number of FIR band cores sequenced.
DATA_W, 16, sample and band-output width, signed.
GAIN_W, 16, gain width, signed Q2.14 (0x4000 = 1.0).
TIMEOUT_CYC, 1024, maximum cycles to wait for a band's done.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_valid  in  1  input sample valid
s_ready  out  1  block can accept a sample
s_data  in  DATA_W  input sample, signed
band_x  out  DATA_W  sample driven to all band cores, held stable for the whole frame
band_start  out  NUM_BAND  one-hot, 1-cycle start pulse to band k
band_done  in  NUM_BAND  done pulse from band k
band_y  in  NUM_BAND*DATA_W  flattened band outputs; band k occupies bits [k*DATA_W +: DATA_W]
gain_we  in  1  gain write strobe
gain_addr  in  3  band index for the write
gain_data  in  GAIN_W  gain value
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts the output
m_data  out  DATA_W  equalized sample, saturated
err_timeout  out  NUM_BAND  sticky per-band timeout flags; cleared only by reset
sat_cnt  out  16  saturation event count (see Optional Feature)

Behaviour:
- Reset values: s_ready=0, band_start=0, band_x=0, m_valid=0, m_data=0, err_timeout=0, sat_cnt=0, band index k=0, accumulator=0. All pending and active gains reset to 0x4000. Reset asserted mid-frame aborts the frame immediately; no partial output is produced.
- FSM states and transitions:
  - IDLE: s_ready=1. On s_valid&&s_ready: latch s_data into band_x, copy pending gains to active gains, clear the accumulator, set k=0, go to START.
  - START: drive band_start[k]=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT: on band_done[k], capture band_y slice k and go to ACC. If the counter reaches TIMEOUT_CYC-1 first, set err_timeout[k], treat the contribution as 0 and go to ACC.
  - ACC: acc += y_k * gain_k. If k<NUM_BAND-1, increment k and go to START; otherwise go to OUT.
  - OUT: load m_data with the saturated result and hold m_valid=1 until m_ready; then go to IDLE.
- s_ready is asserted only in IDLE, one sample per frame.
- Arithmetic:
  - Each product is 32-bit signed.
  - The accumulator is 35-bit signed (32 + ceil(log2 NUM_BAND)).
  - Result = acc >>> 14, saturated to [-32768, 32767].
  - A saturation event is counted when the result is clipped.
- Latency with immediate done from each band: 1 (accept) + NUM_BAND*3 (START/WAIT/ACC) + 1 (OUT) = 17 cycles from accept to m_valid.
- band_done bits for non-active bands, or bits arriving outside WAIT, are ignored. band_done[k] asserted in the same cycle as the timeout expiry counts as done: value captured, no error flag set.
- Gain writes are accepted in any state and go to pending registers. They take effect at the next sample accept, never mid-frame. Writes with gain_addr>=NUM_BAND are ignored.
- m_data holds its value after the handshake until the next OUT load.

Optional Feature:
EQ_SAT_CNT_EN. When defined, sat_cnt increments on each saturated output and sticks at 0xFFFF. When not defined, sat_cnt is tied to 0 and the counter logic is absent; clipping behaviour is unchanged.

Decomposition:
- Package eq_pkg holds: FSM state encoding, GAIN_ONE=16'h4000, the Q2.14 shift constant (14), and the saturation bounds.
- One sub-module: eq_gain_mac, which holds the multiply, the 35-bit accumulate and the shift/saturate; it exposes clear and accumulate enables plus a sat flag.

Test Plan:
- Default gains, s_data=0x1000, every band returns y=0x0800 one cycle after start -> m_data=0x2800, m_valid 17 cycles after accept.
- Gain[2]=0x0000 written before the sample, all bands y=0x1000 -> m_data=0x4000. Same write issued mid-frame -> current output 0x5000, next frame 0x4000.
- All bands y=0x7FFF at unity gain -> m_data=0x7FFF; sat_cnt=1 with EQ_SAT_CNT_EN, 0 without.
- Band 3 never asserts done -> err_timeout=5'b01000 after TIMEOUT_CYC cycles; output equals the sum of the other four bands.
- m_ready held low for 10 cycles in OUT -> m_valid and m_data stable, s_ready=0; new s_valid is not accepted until the handshake completes.
- rst_n pulsed low while in WAIT for band 2 -> all outputs return to reset values; the next sample is processed correctly from band 0.
